// File: rtl/accumulate_seq.sv
// Repeated-addition accumulator: adds X to Sum Y times under a Start/Busy/Done handshake.
// Define ACCUM_SAT_EN to make Sum saturate at all-ones on carry-out instead of wrapping.
module accumulate_seq #(
  parameter int unsigned DATA_W  = 5,
  parameter int unsigned COUNT_W = 5,
  parameter int unsigned SUM_W   = 10
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               Clear,
  input  logic               Start,
  input  logic               Enable,
  input  logic [DATA_W-1:0]  X,
  input  logic [COUNT_W-1:0] Y,
  output logic [SUM_W-1:0]   Sum,
  output logic [COUNT_W-1:0] Count,
  output logic               Busy,
  output logic               Done,
  output logic               Overflow
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [SUM_W:0]   sum_wide;
  logic             carry;
  logic [SUM_W-1:0] sum_next;

  // One extra bit exposes the carry-out of the unsigned add.
  assign sum_wide = {1'b0, Sum} + (SUM_W + 1)'(X);
  assign carry    = sum_wide[SUM_W];

`ifdef ACCUM_SAT_EN
  // Once clamped, later adds of a nonzero X carry again, so Sum stays at all-ones.
  assign sum_next = carry ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
`else
  assign sum_next = sum_wide[SUM_W-1:0];
`endif

  assign Busy = (state_q == StRun);
  assign Done = (state_q == StDone);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= StIdle;
      Sum      <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else if (Clear) begin
      state_q  <= StIdle;
      Sum      <= '0;
      Count    <= '0;
      Overflow <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (Start) begin
            Sum      <= '0;
            Overflow <= 1'b0;
            Count    <= Y;
            state_q  <= (Y != '0) ? StRun : StDone;
          end
        end
        StRun: begin
          // Start is deliberately ignored here: no restart mid-run.
          if (Enable) begin
            Sum      <= sum_next;
            Overflow <= Overflow | carry;
            Count    <= Count - COUNT_W'(1);
            if (Count == COUNT_W'(1)) begin
              state_q <= StDone;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulate_seq.sv
// Directed bench for accumulate_seq: default build plus an SUM_W=8 instance for overflow.
module tb_accumulate_seq;

  logic       Clock;
  logic       Resetn;
  logic       Clear;
  logic       Start;
  logic       Enable;
  logic [4:0] X;
  logic [4:0] Y;

  logic [9:0] sum_a;
  logic [4:0] count_a;
  logic       busy_a, done_a, ovf_a;
  logic [7:0] sum_b;
  logic [4:0] count_b;
  logic       busy_b, done_b, ovf_b;

  int checks = 0;
  int errors = 0;

`ifdef ACCUM_SAT_EN
  localparam int unsigned SumBOvf = 255;
`else
  localparam int unsigned SumBOvf = 193;
`endif

  accumulate_seq #(.DATA_W(5), .COUNT_W(5), .SUM_W(10)) dut_a (
    .Clock(Clock), .Resetn(Resetn), .Clear(Clear), .Start(Start), .Enable(Enable),
    .X(X), .Y(Y), .Sum(sum_a), .Count(count_a), .Busy(busy_a), .Done(done_a),
    .Overflow(ovf_a)
  );

  accumulate_seq #(.DATA_W(5), .COUNT_W(5), .SUM_W(8)) dut_b (
    .Clock(Clock), .Resetn(Resetn), .Clear(Clear), .Start(Start), .Enable(Enable),
    .X(X), .Y(Y), .Sum(sum_b), .Count(count_b), .Busy(busy_b), .Done(done_b),
    .Overflow(ovf_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_a(input string tag, input int unsigned s, input int unsigned c,
                       input int unsigned b, input int unsigned d);
    chk({tag, ".sum"}, sum_a, s);
    chk({tag, ".count"}, count_a, c);
    chk({tag, ".busy"}, busy_a, b);
    chk({tag, ".done"}, done_a, d);
  endtask

  initial begin
    Resetn = 1'b0; Clear = 1'b0; Start = 1'b0; Enable = 1'b1; X = '0; Y = '0;
    #2;
    chk_a("reset", 0, 0, 0, 0);
    chk("reset.ovf", ovf_a, 0);
    #5 Resetn = 1'b1;
    step();
    chk_a("idle_hold", 0, 0, 0, 0);

    // X=3, Y=4: Count 4,3,2,1,0; Done on the 5th edge counting the Start edge.
    X = 5'd3; Y = 5'd4; Start = 1'b1;
    step();
    Start = 1'b0;
    chk_a("t1.e1", 0, 4, 1, 0);
    step(); chk_a("t1.e2", 3, 3, 1, 0);
    step(); chk_a("t1.e3", 6, 2, 1, 0);
    step(); chk_a("t1.e4", 9, 1, 1, 0);
    step(); chk_a("t1.e5", 12, 0, 0, 1);
    chk("t1.ovf", ovf_a, 0);
    step(); chk_a("t1.hold", 12, 0, 0, 1);

    // Y=0 from DONE: straight to DONE with Sum cleared.
    Y = 5'd0; Start = 1'b1;
    step();
    Start = 1'b0;
    chk_a("y0", 0, 0, 0, 1);

    // X=5, Y=3 with a two-cycle pause.
    X = 5'd5; Y = 5'd3; Start = 1'b1;
    step();
    Start = 1'b0;
    chk_a("p.e1", 0, 3, 1, 0);
    step(); chk_a("p.e2", 5, 2, 1, 0);
    Enable = 1'b0;
    step(); chk_a("p.frz1", 5, 2, 1, 0);
    step(); chk_a("p.frz2", 5, 2, 1, 0);
    Enable = 1'b1;
    step(); chk_a("p.e3", 10, 1, 1, 0);
    step(); chk_a("p.e4", 15, 0, 0, 1);

    // X=31, Y=31: 961 fits in 10 bits, overflows 8 bits.
    X = 5'd31; Y = 5'd31; Start = 1'b1;
    step();
    Start = 1'b0;
    chk("ov.start.count", count_b, 31);
    repeat (30) step();
    chk("ov.pre.count", count_b, 1);
    chk("ov.pre.busy", busy_b, 1);
    step();
    chk_a("ov.a", 961, 0, 0, 1);
    chk("ov.a.ovf", ovf_a, 0);
    chk("ov.b.sum", sum_b, SumBOvf);
    chk("ov.b.ovf", ovf_b, 1);
    chk("ov.b.done", done_b, 1);
    chk("ov.b.count", count_b, 0);

    // Clear beats Start in DONE.
    Clear = 1'b1; Start = 1'b1; Y = 5'd3;
    step();
    chk_a("clr", 0, 0, 0, 0);
    chk("clr.ovf_b", ovf_b, 0);
    chk("clr.sum_b", sum_b, 0);
    Clear = 1'b0; X = 5'd1;
    step();
    chk_a("clr.start", 0, 3, 1, 0);
    // Start in RUN with a different Y must not restart.
    Y = 5'd7;
    step();
    Start = 1'b0;
    chk_a("norestart", 1, 2, 1, 0);

    // Async reset mid-RUN at Count=2 takes effect without a clock edge.
    #2 Resetn = 1'b0;
    #1;
    chk_a("arst", 0, 0, 0, 0);
    step();
    chk_a("arst.held", 0, 0, 0, 0);
    #2 Resetn = 1'b1;
    X = 5'd2; Y = 5'd2; Start = 1'b1;
    step();
    Start = 1'b0;
    chk_a("rr.e1", 0, 2, 1, 0);
    step(); chk_a("rr.e2", 2, 1, 1, 0);
    step(); chk_a("rr.e3", 4, 0, 0, 1);

    // Clear in RUN aborts to IDLE.
    X = 5'd4; Y = 5'd5; Start = 1'b1;
    step();
    Start = 1'b0;
    step(); chk_a("cr.run", 4, 4, 1, 0);
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    chk_a("cr.clr", 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
